// File: rtl/memory_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port memory,
// one transaction in flight, with data priority bounded by a fetch-starvation streak.
module memory_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_start,
  output logic              inst_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       inst,
  output logic              inst_valid,

  input  logic              d_cmd_start,
  input  logic              d_cmd_write,
  output logic              d_cmd_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       wmask,
  output logic [31:0]       rdata,
  output logic              rdata_valid,

  output logic              mem_cmd_start,
  output logic              mem_cmd_write,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdata_valid
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t              state_q;
  owner_t              owner_q;
  logic [3:0]          streak_q;
  logic [3:0]          streak_d;
  logic                inst_valid_q;
  logic                rdata_valid_q;
  logic [31:0]         inst_q;
  logic [31:0]         rdata_q;
  logic                cmd_start_q;
  logic                cmd_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         wmask_q;

  logic force_i;
  logic d_grant;
  logic i_grant;

  // Streak only counts data wins that actually kept a fetch waiting.
  always_comb begin
    force_i     = inst_start && (streak_q == STREAK_MAX);
    d_cmd_ready = (state_q == IDLE) && !force_i;
    inst_ready  = (state_q == IDLE) && (!d_cmd_start || force_i);
    d_grant     = d_cmd_start && d_cmd_ready;
    i_grant     = inst_start && inst_ready;
    streak_d    = streak_q;
    if (d_grant) begin
      if (!inst_start) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (i_grant) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_INST;
      streak_q      <= '0;
      inst_valid_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
      inst_q        <= '0;
      rdata_q       <= '0;
      cmd_start_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
    end else begin
      inst_valid_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
      streak_q      <= streak_d;
      unique case (state_q)
        IDLE: begin
          if (d_grant) begin
            owner_q     <= OWN_DATA;
            addr_q      <= d_addr;
            cmd_write_q <= d_cmd_write;
            wdata_q     <= wdata;
            wmask_q     <= wmask;
            cmd_start_q <= 1'b1;
            state_q     <= ISSUE;
          end else if (i_grant) begin
            owner_q     <= OWN_INST;
            addr_q      <= i_addr;
            cmd_write_q <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cmd_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Writes complete on acceptance; only reads wait for a response.
          if (mem_cmd_ready) begin
            cmd_start_q <= 1'b0;
            state_q     <= cmd_write_q ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_rdata_valid) begin
            if (owner_q == OWN_DATA) begin
              rdata_q       <= mem_rdata;
              rdata_valid_q <= 1'b1;
            end else begin
              inst_q       <= mem_rdata;
              inst_valid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst          = inst_q;
  assign inst_valid    = inst_valid_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign mem_cmd_start = cmd_start_q;
  assign mem_cmd_write = cmd_write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: ready table, directed corner sequences and
// randomized traffic against a transaction-level model with a behavioural memory.
module tb_memory_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned AW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_start, inst_ready, inst_valid;
  logic [AW-1:0] i_addr;
  logic [31:0]   inst;
  logic          d_cmd_start, d_cmd_write, d_cmd_ready, rdata_valid;
  logic [AW-1:0] d_addr;
  logic [31:0]   wdata, wmask, rdata;
  logic          mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_wmask, mem_rdata;

  always #5 clk = ~clk;

  memory_port_arbiter #(.MAX_D_STREAK(MAXS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .inst_start(inst_start), .inst_ready(inst_ready), .i_addr(i_addr),
    .inst(inst), .inst_valid(inst_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_cmd_ready(d_cmd_ready),
    .d_addr(d_addr), .wdata(wdata), .wmask(wmask), .rdata(rdata), .rdata_valid(rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  typedef struct {
    bit is;
    bit ds;
    bit e_ir;
    bit e_dr;
  } rdy_vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // transaction-level model
  int unsigned ph;            // 0 free, 1 command pending at memory, 2 read outstanding
  bit          own_d;
  int unsigned m_streak;
  logic [31:0] t_addr, t_wdata, t_wmask, g_addr, g_wdata, g_wmask;
  bit          t_write, g_write;
  logic [31:0] exp_inst, exp_rdata;
  bit          exp_iv, exp_dv;

  // events sampled in the previous cycle
  bit          pv_gi, pv_gd, pv_macc, pv_mwr, pv_mvalid, s_hi, s_hd, s_ir, s_dr, acc_seen, acc_dr;
  logic [31:0] pv_maddr, pv_mdata;

  // memory behaviour
  bit          m_pend, fixed_en, inject, spur_en, rnd_delays;
  int unsigned m_cnt, m_wait, cmd_delay, resp_delay;
  logic [31:0] m_data, fixed_data, inject_data;

  // requesters
  int unsigned i_rate, d_rate;
  bit          d_rd300, q_i, q_d, q_d_wr;
  logic [31:0] q_i_addr, q_d_addr, q_d_wdata, q_d_wmask;

  // statistics
  int          n_iv, n_dv, n_cmd, n_acc, rv_cyc, gi_cyc;
  logic [31:0] last_acc_addr;
  bit          last_acc_wr;
  bit          glog[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic step();
    bit frc, e_ir, e_dr;
    @(negedge clk);
    cyc++;
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    acc_seen = 1'b0;
    if (pv_mvalid && ph == 2) begin
      if (own_d) begin exp_rdata = pv_mdata; exp_dv = 1'b1; end
      else begin exp_inst = pv_mdata; exp_iv = 1'b1; end
      ph = 0;
    end
    if (pv_macc) begin
      n_acc++;
      last_acc_addr = pv_maddr;
      last_acc_wr = pv_mwr;
      if (ph == 1) begin
        ph = t_write ? 0 : 2;
        acc_seen = 1'b1;
      end
    end
    if (pv_gi || pv_gd) begin
      ph = 1;
      own_d = pv_gd;
      t_addr = g_addr; t_write = g_write; t_wdata = g_wdata; t_wmask = g_wmask;
    end

    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_dv));
    chk("inst", inst, exp_inst);
    chk("rdata", rdata, exp_rdata);
    chk("mem_cmd_start", 32'(mem_cmd_start), 32'(ph == 1));
    if (ph == 1) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_cmd_write", 32'(mem_cmd_write), 32'(t_write));
      chk("mem_wdata", mem_wdata, t_wdata);
      chk("mem_wmask", mem_wmask, t_wmask);
    end
    if (inst_valid) n_iv++;
    if (rdata_valid) begin n_dv++; rv_cyc = cyc; end
    if (mem_cmd_start) n_cmd++;

    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    if (pv_macc) begin
      m_wait = 0;
      if (!pv_mwr) begin
        m_pend = 1'b1;
        m_cnt = resp_delay;
        m_data = fixed_en ? fixed_data : mem_word(pv_maddr);
      end
      if (rnd_delays) begin
        cmd_delay = $urandom_range(0, 3);
        resp_delay = $urandom_range(0, 3);
      end
    end
    if (m_pend) begin
      if (m_cnt == 0) begin
        mem_rdata_valid = 1'b1; mem_rdata = m_data; m_pend = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (inject) begin
      mem_rdata_valid = 1'b1; mem_rdata = inject_data; inject = 1'b0;
    end else if (spur_en && ph != 2 && $urandom_range(0, 7) == 0) begin
      mem_rdata_valid = 1'b1; mem_rdata = $urandom;
    end
    if (mem_cmd_start && m_wait >= cmd_delay) begin
      mem_cmd_ready = 1'b1;
    end else begin
      mem_cmd_ready = 1'b0;
      if (mem_cmd_start) m_wait++;
    end

    if (s_hi) inst_start = 1'b0;
    if (s_hd) d_cmd_start = 1'b0;
    if (!inst_start) begin
      if (q_i) begin
        inst_start = 1'b1; i_addr = q_i_addr; q_i = 1'b0;
      end else if ($urandom_range(0, 99) < i_rate) begin
        inst_start = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
    end
    if (!d_cmd_start) begin
      if (q_d) begin
        d_cmd_start = 1'b1; d_cmd_write = q_d_wr; d_addr = q_d_addr;
        wdata = q_d_wdata; wmask = q_d_wmask; q_d = 1'b0;
      end else if ($urandom_range(0, 99) < d_rate) begin
        d_cmd_start = 1'b1;
        d_cmd_write = d_rd300 ? 1'b0 : 1'($urandom_range(0, 1));
        d_addr = d_rd300 ? 32'h300 : ($urandom & 32'hFFFF_FFFC);
        wdata = $urandom; wmask = $urandom;
      end
    end

    #1;
    frc  = inst_start && (m_streak == MAXS);
    e_dr = (ph == 0) && !frc;
    e_ir = (ph == 0) && (d_cmd_start ? frc : 1'b1);
    chk("d_cmd_ready", 32'(d_cmd_ready), 32'(e_dr));
    chk("inst_ready", 32'(inst_ready), 32'(e_ir));
    s_ir = inst_ready;
    s_dr = d_cmd_ready;
    if (acc_seen) acc_dr = d_cmd_ready;
    pv_gd = d_cmd_start && e_dr;
    pv_gi = inst_start && e_ir;
    if (pv_gd) begin
      g_addr = d_addr; g_write = d_cmd_write; g_wdata = wdata; g_wmask = wmask;
      m_streak = inst_start ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    end else if (pv_gi) begin
      g_addr = i_addr; g_write = 1'b0; g_wdata = '0; g_wmask = '0;
      m_streak = 0;
    end
    s_hi = inst_start && inst_ready;
    s_hd = d_cmd_start && d_cmd_ready;
    if (s_hd) glog.push_back(1'b1);
    if (s_hi) begin glog.push_back(1'b0); gi_cyc = cyc; end
    pv_macc = mem_cmd_start && mem_cmd_ready;
    pv_maddr = mem_addr;
    pv_mwr = mem_cmd_write;
    pv_mvalid = mem_rdata_valid;
    pv_mdata = mem_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_start = 1'b0; i_addr = '0; d_cmd_start = 1'b0; d_cmd_write = 1'b0;
    d_addr = '0; wdata = '0; wmask = '0;
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    ph = 0; own_d = 1'b0; m_streak = 0; exp_inst = '0; exp_rdata = '0;
    pv_gi = 0; pv_gd = 0; pv_macc = 0; pv_mwr = 0; pv_mvalid = 0; s_hi = 0; s_hd = 0;
    m_pend = 1'b0; m_wait = 0; inject = 1'b0; q_i = 1'b0; q_d = 1'b0;
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_mem_cmd_start", 32'(mem_cmd_start), 32'h0);
    chk("rst_mem_cmd_write", 32'(mem_cmd_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 32'h0);
    chk("rst_inst_ready", 32'(inst_ready), 32'h1);
    chk("rst_d_cmd_ready", 32'(d_cmd_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_vec_t tbl[4];
    bit       exp_order[10];
    int       b_iv, b_dv, b_acc, b_cmd;

    tbl[0] = '{is: 0, ds: 0, e_ir: 1, e_dr: 1};
    tbl[1] = '{is: 1, ds: 0, e_ir: 1, e_dr: 1};
    tbl[2] = '{is: 0, ds: 1, e_ir: 0, e_dr: 1};
    tbl[3] = '{is: 1, ds: 1, e_ir: 0, e_dr: 1};
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    i_rate = 0; d_rate = 0; d_rd300 = 0; spur_en = 0; rnd_delays = 0; fixed_en = 0;
    cmd_delay = 0; resp_delay = 0; acc_dr = 0; rv_cyc = -1; gi_cyc = -2;
    n_iv = 0; n_dv = 0; n_cmd = 0; n_acc = 0;
    do_reset();

    // combinational ready table, applied and withdrawn within one low phase
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      inst_start = tbl[k].is;
      d_cmd_start = tbl[k].ds;
      #1;
      chk($sformatf("tbl%0d_inst_ready", k), 32'(inst_ready), 32'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_d_cmd_ready", k), 32'(d_cmd_ready), 32'(tbl[k].e_dr));
    end
    inst_start = 1'b0;
    d_cmd_start = 1'b0;
    step();

    // single fetch
    fixed_en = 1; fixed_data = 32'hDEADBEEF; resp_delay = 2;
    b_iv = n_iv; b_dv = n_dv; b_acc = n_acc;
    q_i = 1; q_i_addr = 32'h100;
    repeat (10) step();
    chk("fetch_accepts", 32'(n_acc - b_acc), 32'd1);
    chk("fetch_mem_addr", last_acc_addr, 32'h100);
    chk("fetch_mem_write", 32'(last_acc_wr), 32'h0);
    chk("fetch_inst_pulses", 32'(n_iv - b_iv), 32'd1);
    chk("fetch_rdata_pulses", 32'(n_dv - b_dv), 32'd0);
    chk("fetch_inst", inst, 32'hDEADBEEF);
    fixed_en = 0; resp_delay = 0;

    // data write with a slow memory
    cmd_delay = 3; acc_dr = 0;
    b_iv = n_iv; b_dv = n_dv; b_cmd = n_cmd;
    q_d = 1; q_d_wr = 1; q_d_addr = 32'h200; q_d_wdata = 32'h12345678; q_d_wmask = 32'h0000FFFF;
    repeat (10) step();
    chk("write_cmd_cycles", 32'(n_cmd - b_cmd), 32'd4);
    chk("write_no_inst_pulse", 32'(n_iv - b_iv), 32'd0);
    chk("write_no_rdata_pulse", 32'(n_dv - b_dv), 32'd0);
    chk("write_ready_after_accept", 32'(acc_dr), 32'h1);
    chk("write_mem_addr", last_acc_addr, 32'h200);
    chk("write_mem_write", 32'(last_acc_wr), 32'h1);
    cmd_delay = 0;

    // simultaneous requests, streak at zero
    q_i = 1; q_i_addr = 32'h180;
    q_d = 1; q_d_wr = 0; q_d_addr = 32'h300; q_d_wdata = '0; q_d_wmask = '0;
    step();
    chk("both_inst_ready", 32'(s_ir), 32'h0);
    chk("both_d_cmd_ready", 32'(s_dr), 32'h1);
    repeat (12) step();
    chk("fetch_in_rdata_pulse_cycle", 32'(gi_cyc), 32'(rv_cyc));
    chk("both_rdata", rdata, mem_word(32'h300));
    chk("both_inst", inst, mem_word(32'h180));

    // continuous contention: streak limit forces fetches through
    do_reset();
    glog.delete();
    i_rate = 100; d_rate = 100; d_rd300 = 1;
    for (int k = 0; k < 200 && glog.size() < 10; k++) step();
    chk("order_count_reached", 32'(glog.size() >= 10), 32'h1);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("order%0d_is_data", k), 32'(glog[k]), 32'(exp_order[k]));
    i_rate = 0; d_rate = 0; d_rd300 = 0;
    repeat (12) step();

    // reset while a read is outstanding, then a late response
    do_reset();
    resp_delay = 6;
    q_i = 1; q_i_addr = 32'h40;
    repeat (4) step();
    chk("midrst_outstanding", 32'(ph), 32'd2);
    do_reset();
    b_iv = n_iv; b_dv = n_dv;
    inject = 1; inject_data = 32'hCAFEF00D;
    repeat (2) step();
    chk("late_no_inst_pulse", 32'(n_iv - b_iv), 32'd0);
    chk("late_no_rdata_pulse", 32'(n_dv - b_dv), 32'd0);
    chk("late_inst_zero", inst, 32'h0);
    chk("late_rdata_zero", rdata, 32'h0);
    chk("late_idle_inst_ready", 32'(s_ir), 32'h1);
    chk("late_idle_d_ready", 32'(s_dr), 32'h1);
    resp_delay = 0;
    b_iv = n_iv;
    q_i = 1; q_i_addr = 32'h80;
    repeat (6) step();
    chk("after_rst_fetch_pulses", 32'(n_iv - b_iv), 32'd1);
    chk("after_rst_fetch_inst", inst, mem_word(32'h80));

    // spurious response while the command is still waiting for acceptance
    cmd_delay = 3;
    b_iv = n_iv;
    q_i = 1; q_i_addr = 32'h140;
    step();
    step();
    inject = 1; inject_data = 32'hBADBAD00;
    repeat (10) step();
    chk("spur_inst_pulses", 32'(n_iv - b_iv), 32'd1);
    chk("spur_inst", inst, mem_word(32'h140));
    cmd_delay = 0;

    // randomized traffic
    do_reset();
    rnd_delays = 1; spur_en = 1; i_rate = 60; d_rate = 70;
    repeat (3000) step();
    i_rate = 0; d_rate = 0; spur_en = 0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
